flag_stack_register: RTL and testbench
======================================

// Module: flag_stack_register
// PURPOSE
//  Parametrised CPU status-flag register with a hardware save/restore stack for nested interrupts.
//  Sits beside the ALU and decoder. The decoder turns each instruction into per-flag update masks
//  and explicit set/load controls, so no opcode table lives in this block.
//  On interrupt entry (push) the current flags are saved and I is cleared. On return (pop) the
//  saved flags are restored. Outputs feed branch-condition logic and the interrupt controller.
// PARAMETERS
//  NFLAGS     8  number of flag bits (>= 6)
//  DEPTH      4  save-stack entries (>= 1)
//  ALWAYS_BIT 5  index of the A (always-true) flag; reads 1 at all times
//  IRQ_BIT    4  index of the I (interrupt-enable) flag; cleared on push
// PORTS
//  clk       in   1                   rising-edge clock
//  reset     in   1                   asynchronous, active-high reset
//  alu_flags in   NFLAGS              flag values produced by the ALU this cycle
//  upd_mask  in   NFLAGS              1 = take alu_flags bit this cycle (e.g. 8'h0F for ADD, 8'h05 for AND)
//  set_en    in   1                   single-flag write (LDFI)
//  set_sel   in   $clog2(NFLAGS)      flag index for set_en
//  set_val   in   1                   value for set_en
//  load_en   in   1                   whole-register load (MOVF)
//  load_val  in   NFLAGS              value for load_en
//  push      in   1                   save flags, clear I (interrupt entry)
//  pop       in   1                   restore flags (interrupt return)
//  flags     out  NFLAGS              registered flag state
//  depth     out  $clog2(DEPTH+1)     occupied stack entries
//  empty     out  1                   depth == 0
//  full      out  1                   depth == DEPTH
//  ovf_err   out  1                   sticky: push attempted while full
//  udf_err   out  1                   sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, any time including mid-push/pop):
//   - flags = 1 << ALWAYS_BIT; depth = 0; empty = 1; full = 0; ovf_err = udf_err = 0.
//   - Stack RAM contents are don't-care after reset.
//  State changes on the rising clk edge only. All outputs are registered and reflect a request
//  one cycle later. No combinational input->output path.
//  Stack operations, evaluated before flag updates:
//   - push & !pop & !full: stack[depth] <= flags; depth++; flags <= flags with IRQ_BIT cleared.
//     All other flag sources are ignored that cycle.
//   - pop & !push & !empty: flags <= stack[depth-1] with ALWAYS_BIT forced 1; depth--.
//     All other flag sources are ignored that cycle.
//   - push & full: no stack or flag change from the push; ovf_err <= 1. Normal updates still apply.
//   - pop & empty: no change from the pop; udf_err <= 1. Normal updates still apply.
//   - push & pop together: both ignored (no error, depth unchanged). Normal updates apply.
//  Normal update, when no stack operation took effect, applied in order (later wins):
//   1. n = (flags & ~upd_mask) | (alu_flags & upd_mask)
//   2. if set_en && set_sel < NFLAGS && set_sel != ALWAYS_BIT: n[set_sel] = set_val
//      (otherwise the set is ignored)
//   3. if load_en: n = load_val
//   4. n[ALWAYS_BIT] = 1; flags <= n
//  Error flags: ovf_err and udf_err are sticky and clear only on reset.
//  Stack indexing: pointer = depth, no wrap-around; full/empty block overrun.
//  Status outputs: full/empty are registered and consistent with depth every cycle.
// TESTING (NFLAGS=8, DEPTH=4, ALWAYS_BIT=5, IRQ_BIT=4)
//  1. Reset, then idle -> flags=8'h20, depth=0, empty=1, errs=0. Assert reset mid-push -> same values immediately.
//  2. flags=8'h20; upd_mask=8'h0F, alu_flags=8'hFF -> 8'h2F. Next cycle upd_mask=8'h05, alu_flags=8'h00 -> 8'h2A.
//  3. set_en sel=4 val=1 -> 8'h30. set_en sel=5 val=0 -> unchanged 8'h30. load_en load_val=8'h00 -> 8'h20.
//  4. flags=8'h3F; push -> flags=8'h2F, depth=1. An upd_mask in the push cycle is ignored.
//     pop -> flags=8'h3F, depth=0.
//  5. Push 4 times -> full=1. 5th push -> depth stays 4, ovf_err=1. 4 pops restore in LIFO order.
//     5th pop -> udf_err=1, flags unchanged.
//  6. push & pop same cycle with upd_mask=8'h01, alu_flags=8'h01 -> depth unchanged, flags[0]=1, no error.

Source files
------------

// File: rtl/flag_stack_register_if.sv
// Decoder/ALU-side bus of the flag stack register: update controls in, flag state and stack status out.
interface flag_stack_register_if #(
    parameter int NFLAGS = 8,
    parameter int DEPTH  = 4
);
    logic [NFLAGS-1:0]          alu_flags;
    logic [NFLAGS-1:0]          upd_mask;
    logic                       set_en;
    logic [$clog2(NFLAGS)-1:0]  set_sel;
    logic                       set_val;
    logic                       load_en;
    logic [NFLAGS-1:0]          load_val;
    logic                       push;
    logic                       pop;
    logic [NFLAGS-1:0]          flags;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       empty;
    logic                       full;
    logic                       ovf_err;
    logic                       udf_err;

    modport master (
        output alu_flags, upd_mask, set_en, set_sel, set_val, load_en, load_val, push, pop,
        input  flags, depth, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  alu_flags, upd_mask, set_en, set_sel, set_val, load_en, load_val, push, pop,
        output flags, depth, empty, full, ovf_err, udf_err
    );
endinterface

// File: rtl/flag_stack_register.sv
// CPU status-flag register with a LIFO save/restore stack for nested interrupts.
module flag_stack_register #(
    parameter int NFLAGS     = 8,
    parameter int DEPTH      = 4,
    parameter int ALWAYS_BIT = 5,
    parameter int IRQ_BIT    = 4
) (
    input logic                   clk,
    input logic                   reset,
    flag_stack_register_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags_q, flags_d, upd_n;
    logic [DW-1:0]     depth_q, depth_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [NFLAGS-1:0] stack_q [DEPTH];
    logic [AW-1:0]     wr_idx, rd_idx;
    logic              push_ok, pop_ok;

    // Simultaneous push and pop cancel each other and raise no error.
    assign push_ok = bus.push & ~bus.pop & ~full_q;
    assign pop_ok  = bus.pop & ~bus.push & ~empty_q;
    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));

    always_comb begin
        upd_n = (flags_q & ~bus.upd_mask) | (bus.alu_flags & bus.upd_mask);
        if (bus.set_en && int'(bus.set_sel) < NFLAGS && int'(bus.set_sel) != ALWAYS_BIT)
            upd_n[bus.set_sel] = bus.set_val;
        if (bus.load_en)
            upd_n = bus.load_val;
        upd_n[ALWAYS_BIT] = 1'b1;
    end

    always_comb begin
        flags_d = upd_n;
        depth_d = depth_q;
        if (push_ok) begin
            flags_d          = flags_q;
            flags_d[IRQ_BIT] = 1'b0;
            depth_d          = depth_q + DW'(1);
        end else if (pop_ok) begin
            flags_d             = stack_q[rd_idx];
            flags_d[ALWAYS_BIT] = 1'b1;
            depth_d             = depth_q - DW'(1);
        end
        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(DEPTH));
        ovf_d   = ovf_q | (bus.push & ~bus.pop & full_q);
        udf_d   = udf_q | (bus.pop & ~bus.push & empty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= NFLAGS'(1) << ALWAYS_BIT;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Stack contents need no reset; depth alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            stack_q[wr_idx] <= flags_q;
    end

    assign bus.flags   = flags_q;
    assign bus.depth   = depth_q;
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
endmodule

// File: tb/tb_flag_stack_register.sv
// Self-checking bench for flag_stack_register: directed scenarios plus random traffic against a queue model.
module tb_flag_stack_register;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    flag_stack_register_if #(.NFLAGS(8), .DEPTH(4)) bus ();

    flag_stack_register #(.NFLAGS(8), .DEPTH(4), .ALWAYS_BIT(5), .IRQ_BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: flags word, a queue as the save stack, sticky errors.
    logic [7:0] mflags;
    logic [7:0] mstack[$];
    logic       movf, mudf;

    task automatic model_reset();
        mflags = 8'h20;
        mstack.delete();
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] nf;
        if (bus.push && !bus.pop && mstack.size() == 4) movf = 1'b1;
        if (bus.pop && !bus.push && mstack.size() == 0) mudf = 1'b1;
        if (bus.push && !bus.pop && mstack.size() < 4) begin
            mstack.push_back(mflags);
            mflags[4] = 1'b0;
        end else if (bus.pop && !bus.push && mstack.size() > 0) begin
            mflags = mstack.pop_back();
            mflags[5] = 1'b1;
        end else begin
            nf = mflags;
            for (int i = 0; i < 8; i++)
                if (bus.upd_mask[i]) nf[i] = bus.alu_flags[i];
            if (bus.set_en && bus.set_sel != 3'd5) nf[bus.set_sel] = bus.set_val;
            if (bus.load_en) nf = bus.load_val;
            nf[5] = 1'b1;
            mflags = nf;
        end
    endtask

    task automatic idle_inputs();
        bus.alu_flags = '0; bus.upd_mask = '0;
        bus.set_en = 1'b0; bus.set_sel = '0; bus.set_val = 1'b0;
        bus.load_en = 1'b0; bus.load_val = '0;
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    // One clock: apply the currently driven inputs, advance the model, then return idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        total++;
        if (bus.flags !== 8'h20 || bus.depth !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: flags=%h depth=%0d empty=%b full=%b ovf=%b udf=%b want 20/0/1/0/0/0",
                     bus.flags, bus.depth, bus.empty, bus.full, bus.ovf_err, bus.udf_err);
        end
        bus.push = 1'b1;
        cyc();
        total++;
        if (bus.depth !== 3'd1) begin
            bad++;
            $display("FAIL pre_reset_push: depth=%0d want 1", bus.depth);
        end
        bus.push = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (bus.flags !== 8'h20 || bus.depth !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_push: flags=%h depth=%0d empty=%b want 20/0/1", bus.flags, bus.depth, bus.empty);
        end
        do_reset();
    endtask

    task automatic test_mask_update();
        bus.upd_mask = 8'h0F; bus.alu_flags = 8'hFF;
        cyc();
        total++;
        if (bus.flags !== 8'h2F) begin
            bad++;
            $display("FAIL mask_add: flags=%h want 2f", bus.flags);
        end
        bus.upd_mask = 8'h05; bus.alu_flags = 8'h00;
        cyc();
        total++;
        if (bus.flags !== 8'h2A) begin
            bad++;
            $display("FAIL mask_and: flags=%h want 2a", bus.flags);
        end
    endtask

    task automatic test_set_load();
        bus.load_en = 1'b1; bus.load_val = 8'h00;
        cyc();
        bus.set_en = 1'b1; bus.set_sel = 3'd4; bus.set_val = 1'b1;
        cyc();
        total++;
        if (bus.flags !== 8'h30) begin
            bad++;
            $display("FAIL set_irq: flags=%h want 30", bus.flags);
        end
        bus.set_en = 1'b1; bus.set_sel = 3'd5; bus.set_val = 1'b0;
        cyc();
        total++;
        if (bus.flags !== 8'h30) begin
            bad++;
            $display("FAIL set_always_ignored: flags=%h want 30", bus.flags);
        end
        bus.load_en = 1'b1; bus.load_val = 8'h00;
        bus.set_en = 1'b1; bus.set_sel = 3'd1; bus.set_val = 1'b1;
        cyc();
        total++;
        if (bus.flags !== 8'h20) begin
            bad++;
            $display("FAIL load_wins: flags=%h want 20", bus.flags);
        end
    endtask

    task automatic test_push_pop();
        bus.load_en = 1'b1; bus.load_val = 8'h3F;
        cyc();
        bus.push = 1'b1; bus.upd_mask = 8'hFF; bus.alu_flags = 8'h00;
        cyc();
        total++;
        if (bus.flags !== 8'h2F || bus.depth !== 3'd1 || bus.empty !== 1'b0) begin
            bad++;
            $display("FAIL push: flags=%h depth=%0d empty=%b want 2f/1/0", bus.flags, bus.depth, bus.empty);
        end
        bus.pop = 1'b1; bus.load_en = 1'b1; bus.load_val = 8'h00;
        cyc();
        total++;
        if (bus.flags !== 8'h3F || bus.depth !== 3'd0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL pop: flags=%h depth=%0d empty=%b want 3f/0/1", bus.flags, bus.depth, bus.empty);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] ld[4];
        logic [7:0] exp_pop[4];
        ld = '{8'h11, 8'h92, 8'h43, 8'h1C};
        exp_pop = '{8'h3C, 8'h63, 8'hB2, 8'h31};
        for (int i = 0; i < 4; i++) begin
            bus.load_en = 1'b1; bus.load_val = ld[i];
            cyc();
            bus.push = 1'b1;
            cyc();
        end
        total++;
        if (bus.full !== 1'b1 || bus.depth !== 3'd4 || bus.flags !== 8'h2C) begin
            bad++;
            $display("FAIL fill: full=%b depth=%0d flags=%h want 1/4/2c", bus.full, bus.depth, bus.flags);
        end
        bus.push = 1'b1;
        cyc();
        total++;
        if (bus.depth !== 3'd4 || bus.ovf_err !== 1'b1 || bus.flags !== 8'h2C || bus.udf_err !== 1'b0) begin
            bad++;
            $display("FAIL overflow: depth=%0d ovf=%b udf=%b flags=%h want 4/1/0/2c",
                     bus.depth, bus.ovf_err, bus.udf_err, bus.flags);
        end
        for (int i = 0; i < 4; i++) begin
            bus.pop = 1'b1;
            cyc();
            total++;
            if (bus.flags !== exp_pop[i] || bus.depth !== 3'(3 - i)) begin
                bad++;
                $display("FAIL lifo_pop%0d: flags=%h depth=%0d want %h/%0d", i, bus.flags, bus.depth, exp_pop[i], 3 - i);
            end
        end
        bus.pop = 1'b1;
        cyc();
        total++;
        if (bus.udf_err !== 1'b1 || bus.flags !== 8'h31 || bus.depth !== 3'd0 || bus.empty !== 1'b1 ||
            bus.ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL underflow: udf=%b flags=%h depth=%0d ovf=%b want 1/31/0/1",
                     bus.udf_err, bus.flags, bus.depth, bus.ovf_err);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        bus.push = 1'b1;
        cyc();
        bus.push = 1'b1; bus.pop = 1'b1; bus.upd_mask = 8'h01; bus.alu_flags = 8'h01;
        cyc();
        total++;
        if (bus.depth !== 3'd1 || bus.flags !== 8'h21 || bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) begin
            bad++;
            $display("FAIL push_pop_same: depth=%0d flags=%h ovf=%b udf=%b want 1/21/0/0",
                     bus.depth, bus.flags, bus.ovf_err, bus.udf_err);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.alu_flags = 8'($urandom);
            bus.upd_mask  = 8'($urandom);
            bus.set_en    = ($urandom_range(0, 3) == 0);
            bus.set_sel   = 3'($urandom_range(0, 7));
            bus.set_val   = 1'($urandom);
            bus.load_en   = ($urandom_range(0, 7) == 0);
            bus.load_val  = 8'($urandom);
            bus.push      = ($urandom_range(0, 3) == 0);
            bus.pop       = ($urandom_range(0, 3) == 0);
            cyc();
            total++;
            if (bus.flags !== mflags || bus.depth !== 3'(mstack.size()) ||
                bus.empty !== (mstack.size() == 0) || bus.full !== (mstack.size() == 4) ||
                bus.ovf_err !== movf || bus.udf_err !== mudf) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL random[%0d]: flags=%h depth=%0d ovf=%b udf=%b want %h/%0d/%b/%b",
                             n, bus.flags, bus.depth, bus.ovf_err, bus.udf_err,
                             mflags, mstack.size(), movf, mudf);
            end
            if (n == 200) do_reset();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_mask_update();
        test_set_load();
        test_push_pop();
        test_overflow_underflow();
        test_push_pop_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
